// File: rtl/load_store_unit.sv
// Memory-access/writeback stage: one transaction in flight, valid/ready data bus, aligned and extended writeback.
// Build option MISALIGN_TRAP_EN: misaligned halfword/word accesses fault instead of having their low address bits ignored.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        dbus_valid,
    input  logic        dbus_ready,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_WB} state_t;
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;

    logic        req_ready_q, req_ready_d, dbus_valid_q, dbus_valid_d, dbus_we_q, dbus_we_d;
    logic [31:0] dbus_addr_q, dbus_addr_d, dbus_wdata_q, dbus_wdata_d, wb_data_q, wb_data_d;
    logic [3:0]  dbus_be_q, dbus_be_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_we_q, wb_we_d, done_q, done_d, err_q, err_d;

    logic        accept, is_mem, ld_ok, st_ok, misal, bad, timeout_hit;
    logic [3:0]  st_be;
    logic [31:0] st_data, ld_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        accept = req_valid && (state_q == S_IDLE);
        is_mem = mem_read || mem_write;
        ld_ok  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_ok  = funct3 inside {3'b000, 3'b001, 3'b010};
`ifdef MISALIGN_TRAP_EN
        misal  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        misal  = 1'b0;
`endif
        bad = (mem_read && mem_write) || (mem_read && !ld_ok) ||
              (mem_write && !st_ok) || (is_mem && misal);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LIMIT);
    end

    // Stores replicate the operand across lanes so the byte enables alone pick the target.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_be   = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = wdata;
            end
        endcase
    end

    always_comb begin
        case (off_q)
            2'b00:   ld_byte = dbus_rdata[7:0];
            2'b01:   ld_byte = dbus_rdata[15:8];
            2'b10:   ld_byte = dbus_rdata[23:16];
            default: ld_byte = dbus_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = dbus_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_load_d = is_load_q;
        f3_d      = f3_q;
        off_d     = off_q;
        rd_d      = rd_q;
        case (state_q)
            S_IDLE: if (accept) begin
                is_load_d = mem_read;
                f3_d      = funct3;
                off_d     = addr[1:0];
                rd_d      = rd;
                cnt_d     = '0;
                state_d   = (is_mem && !bad) ? S_REQ : S_WB;
            end
            S_REQ: begin
                if (dbus_ready) begin
                    state_d = is_load_q ? S_RESP : S_WB;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RESP: begin
                if (dbus_rvalid || timeout_hit) state_d = S_WB;
                else                            cnt_d   = cnt_q + 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_d  = (state_d == S_IDLE);
        dbus_valid_d = (state_d == S_REQ);
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_be_d    = dbus_be_q;
        dbus_wdata_d = dbus_wdata_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        wb_we_d      = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                if (is_mem && !bad) begin
                    dbus_we_d    = mem_write;
                    dbus_addr_d  = {addr[31:2], 2'b00};
                    dbus_be_d    = mem_write ? st_be : 4'b0000;
                    dbus_wdata_d = mem_write ? st_data : 32'd0;
                end else begin
                    done_d    = 1'b1;
                    err_d     = bad;
                    wb_we_d   = !bad && (rd != 5'd0);
                    wb_rd_d   = rd;
                    wb_data_d = bad ? 32'd0 : addr;
                end
            end
            S_REQ: if (state_d == S_WB) begin
                done_d    = 1'b1;
                err_d     = !dbus_ready;
                wb_rd_d   = rd_q;
                wb_data_d = 32'd0;
            end
            S_RESP: if (state_d == S_WB) begin
                done_d  = 1'b1;
                wb_rd_d = rd_q;
                if (dbus_rvalid) begin
                    wb_we_d   = (rd_q != 5'd0);
                    wb_data_d = ld_val;
                end else begin
                    err_d     = 1'b1;
                    wb_data_d = 32'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            is_load_q    <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            req_ready_q  <= 1'b1;
            dbus_valid_q <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_be_q    <= '0;
            dbus_wdata_q <= '0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_load_q    <= is_load_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            req_ready_q  <= req_ready_d;
            dbus_valid_q <= dbus_valid_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_be_q    <= dbus_be_d;
            dbus_wdata_q <= dbus_wdata_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign dbus_valid = dbus_valid_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_be    = dbus_be_q;
    assign dbus_wdata = dbus_wdata_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (TIMEOUT_CYCLES=4): directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk, rst_n, req_valid, req_ready, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, dbus_addr, dbus_wdata, dbus_rdata, wb_data;
    logic [4:0]  rd, wb_rd;
    logic        dbus_valid, dbus_ready, dbus_we, dbus_rvalid, wb_we, done, err;
    logic [3:0]  dbus_be;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rd(rd), .dbus_valid(dbus_valid), .dbus_ready(dbus_ready),
        .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Reference: what one instruction must produce, from the access rules alone.
    function automatic void model(input logic mr, input logic mw, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                                  input logic [4:0] r, input int rdy, input int rv,
                                  output bit bus, output logic [31:0] e_addr, output logic [3:0] e_be,
                                  output logic [31:0] e_wd, output logic e_err, output logic e_wbwe,
                                  output logic [31:0] e_wbd, output int e_lat, output int e_vcnt);
        int size, off, eoff, reqc;
        bit ill;
        logic [63:0] mask, raw;
        size = 1 << f3[1:0];
        off  = int'(a[1:0]);
        eoff = (off / size) * size;
        ill  = (mr && mw) || (mr && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
               (mw && !(f3 inside {3'b000, 3'b001, 3'b010}));
`ifdef MISALIGN_TRAP_EN
        if ((mr || mw) && (off % size != 0)) ill = 1'b1;
`endif
        bus    = (mr || mw) && !ill;
        e_addr = a & 32'hFFFF_FFFC;
        e_be   = 4'd0;
        e_wd   = 32'd0;
        if (mw) begin
            e_be = 4'(((1 << size) - 1) << eoff);
            case (size)
                1:       e_wd = (wd & 32'hFF) * 32'h0101_0101;
                2:       e_wd = (wd & 32'hFFFF) * 32'h0001_0001;
                default: e_wd = wd;
            endcase
        end
        mask = (64'd1 << (8 * size)) - 64'd1;
        raw  = ({32'd0, rdat} >> (8 * eoff)) & mask;
        if (!f3[2] && size < 4 && raw[8 * size - 1]) raw = raw | ~mask;
        e_wbd  = raw[31:0];
        e_err  = 1'b0;
        e_wbwe = 1'b0;
        e_vcnt = 0;
        e_lat  = 1;
        if (!(mr || mw)) begin
            e_wbwe = (r != 5'd0);
            e_wbd  = a;
        end else if (ill) begin
            e_err = 1'b1;
        end else begin
            reqc   = (rdy < 0) ? TO + 1 : rdy + 1;
            e_vcnt = reqc;
            e_lat  = 1 + reqc;
            if (rdy < 0) e_err = 1'b1;
            else if (mr) begin
                e_lat += (rv < 0) ? TO + 1 : rv + 1;
                if (rv < 0) e_err = 1'b1;
                else        e_wbwe = (r != 5'd0);
            end
        end
    endfunction

    // Issues one instruction and plays the bus; returns what was observed (no checking here).
    task automatic do_txn(input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] r, input logic [31:0] rdat,
                          input int rdy, input int rv,
                          output int lat, output int vcnt, output bit stab,
                          output logic [31:0] o_addr, output logic o_we, output logic [3:0] o_be,
                          output logic [31:0] o_wd, output logic o_err, output logic o_wbwe,
                          output logic [4:0] o_wbrd, output logic [31:0] o_wbd, output bit pulse_ok);
        bit in_resp, got;
        int rc, guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        req_valid = 1'b1; mem_read = mr; mem_write = mw; funct3 = f3; addr = a; wdata = wd; rd = r;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom; rd = 5'($urandom);
        lat = -1; vcnt = 0; stab = 1'b1; in_resp = 1'b0; rc = 0; got = 1'b0; pulse_ok = 1'b0;
        o_addr = '0; o_we = 1'b0; o_be = '0; o_wd = '0; o_err = 1'b0; o_wbwe = 1'b0; o_wbrd = '0; o_wbd = '0;
        for (int c = 1; c <= 60 && !got; c++) begin
            dbus_ready = 1'b0; dbus_rvalid = 1'($urandom); dbus_rdata = $urandom;
            if (done) begin
                got = 1'b1; lat = c; o_err = err; o_wbwe = wb_we; o_wbrd = wb_rd; o_wbd = wb_data;
            end else if (dbus_valid) begin
                if (vcnt == 0) begin
                    o_addr = dbus_addr; o_we = dbus_we; o_be = dbus_be; o_wd = dbus_wdata;
                end else if ({o_addr, o_we, o_be, o_wd} !== {dbus_addr, dbus_we, dbus_be, dbus_wdata}) begin
                    stab = 1'b0;
                end
                dbus_ready = (rdy >= 0) && (vcnt >= rdy);
                vcnt++;
                if (dbus_ready && !dbus_we) in_resp = 1'b1;
            end else if (in_resp) begin
                dbus_rvalid = (rv >= 0) && (rc >= rv);
                if (dbus_rvalid) dbus_rdata = rdat;
                rc++;
            end
            @(posedge clk); #1;
        end
        dbus_ready = 1'b0; dbus_rvalid = 1'b1;
        if (got) pulse_ok = !done && !err && !wb_we && req_ready;
        dbus_rvalid = 1'b0;
    endtask

    int lat, vcnt;
    bit stab, pls;
    logic [31:0] o_addr, o_wd, o_wbd;
    logic [3:0] o_be;
    logic o_we, o_err, o_wbwe;
    logic [4:0] o_wbrd;

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        checks++; if ({dbus_valid, dbus_we, dbus_addr, dbus_be, dbus_wdata} !== '0) begin
            errors++; $display("FAIL reset_dbus got=%b/%b/%h/%b/%h want=all 0", dbus_valid, dbus_we, dbus_addr, dbus_be, dbus_wdata); end
        checks++; if ({wb_we, wb_rd, wb_data, done, err} !== '0) begin
            errors++; $display("FAIL reset_wb got=%b/%h/%h/%b/%b want=all 0", wb_we, wb_rd, wb_data, done, err); end
    endtask

    task automatic test_lw();
        do_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0,
               lat, vcnt, stab, o_addr, o_we, o_be, o_wd, o_err, o_wbwe, o_wbrd, o_wbd, pls);
        checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got=%h want=00000100", o_addr); end
        checks++; if (o_be !== 4'b0000 || o_we !== 1'b0) begin errors++; $display("FAIL lw_be_we got=%b/%b want=0000/0", o_be, o_we); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got=%0d want=3", lat); end
        checks++; if ({o_wbwe, o_err, o_wbrd, o_wbd} !== {1'b1, 1'b0, 5'd5, 32'hDEADBEEF}) begin
            errors++; $display("FAIL lw_wb got=we%b err%b rd%0d %h want=we1 err0 rd5 deadbeef", o_wbwe, o_err, o_wbrd, o_wbd); end
        checks++; if (!pls) begin errors++; $display("FAIL lw_pulse got=not single-cycle want=single-cycle"); end
    endtask

    task automatic test_lb_lbu();
        do_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 32'h80FF_0000, 0, 0,
               lat, vcnt, stab, o_addr, o_we, o_be, o_wd, o_err, o_wbwe, o_wbrd, o_wbd, pls);
        checks++; if (o_wbd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got=%h want=ffffff80", o_wbd); end
        do_txn(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 32'h80FF_0000, 0, 0,
               lat, vcnt, stab, o_addr, o_we, o_be, o_wd, o_err, o_wbwe, o_wbrd, o_wbd, pls);
        checks++; if (o_wbd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got=%h want=00000080", o_wbd); end
    endtask

    task automatic test_sh_wait();
        do_txn(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd3, 32'h0, 3, 0,
               lat, vcnt, stab, o_addr, o_we, o_be, o_wd, o_err, o_wbwe, o_wbrd, o_wbd, pls);
        checks++; if (vcnt !== 4 || !stab) begin errors++; $display("FAIL sh_valid_hold got=%0d cycles stable=%b want=4 stable=1", vcnt, stab); end
        checks++; if ({o_we, o_be, o_wd, o_addr} !== {1'b1, 4'b1100, 32'hABCD_ABCD, 32'h200}) begin
            errors++; $display("FAIL sh_bus got=%b/%b/%h/%h want=1/1100/abcdabcd/00000200", o_we, o_be, o_wd, o_addr); end
        checks++; if (lat !== 5 || o_wbwe !== 1'b0 || o_err !== 1'b0) begin
            errors++; $display("FAIL sh_done got=lat%0d we%b err%b want=lat5 we0 err0", lat, o_wbwe, o_err); end
    endtask

    task automatic test_timeout();
        do_txn(1'b0, 1'b1, 3'b010, 32'h300, 32'h1, 5'd2, 32'h0, -1, 0,
               lat, vcnt, stab, o_addr, o_we, o_be, o_wd, o_err, o_wbwe, o_wbrd, o_wbd, pls);
        checks++; if (vcnt !== TO + 1 || lat !== TO + 2) begin errors++; $display("FAIL to_req got=valid%0d lat%0d want=valid5 lat6", vcnt, lat); end
        checks++; if (o_err !== 1'b1 || o_wbwe !== 1'b0) begin errors++; $display("FAIL to_req_err got=err%b we%b want=err1 we0", o_err, o_wbwe); end
        do_txn(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 5'd2, 32'h0, 0, -1,
               lat, vcnt, stab, o_addr, o_we, o_be, o_wd, o_err, o_wbwe, o_wbrd, o_wbd, pls);
        checks++; if (lat !== TO + 3 || o_err !== 1'b1 || o_wbwe !== 1'b0) begin
            errors++; $display("FAIL to_resp got=lat%0d err%b we%b want=lat7 err1 we0", lat, o_err, o_wbwe); end
        for (int i = 0; i < 3; i++) begin
            dbus_rvalid = 1'b1; dbus_rdata = 32'h1111_1111;
            @(posedge clk); #1;
            checks++; if (done !== 1'b0 || wb_we !== 1'b0) begin errors++; $display("FAIL late_rvalid got=done%b we%b want=0/0", done, wb_we); end
        end
        dbus_rvalid = 1'b0;
    endtask

    task automatic test_misaligned();
        do_txn(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd9, 32'h1122_3344, 0, 0,
               lat, vcnt, stab, o_addr, o_we, o_be, o_wd, o_err, o_wbwe, o_wbrd, o_wbd, pls);
`ifdef MISALIGN_TRAP_EN
        checks++; if (lat !== 1 || vcnt !== 0 || o_err !== 1'b1 || o_wbwe !== 1'b0) begin
            errors++; $display("FAIL misalign_trap got=lat%0d valid%0d err%b we%b want=1/0/1/0", lat, vcnt, o_err, o_wbwe); end
`else
        checks++; if (o_addr !== 32'h100 || lat !== 3 || o_err !== 1'b0 || o_wbd !== 32'h1122_3344) begin
            errors++; $display("FAIL misalign_lw got=%h lat%0d err%b %h want=00000100 lat3 err0 11223344", o_addr, lat, o_err, o_wbd); end
`endif
    endtask

    task automatic test_rd0_and_reset_mid();
        do_txn(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd0, 32'h55, 0, 0,
               lat, vcnt, stab, o_addr, o_we, o_be, o_wd, o_err, o_wbwe, o_wbrd, o_wbd, pls);
        checks++; if (lat !== 3 || o_wbwe !== 1'b0 || o_err !== 1'b0) begin
            errors++; $display("FAIL rd0_load got=lat%0d we%b err%b want=lat3 we0 err0", lat, o_wbwe, o_err); end
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h80; rd = 5'd6;
        @(posedge clk); #1;
        req_valid = 1'b0; dbus_ready = 1'b1;
        @(posedge clk); #1;
        dbus_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || {dbus_valid, dbus_we, dbus_addr, dbus_be, dbus_wdata, wb_we, wb_rd, wb_data, done, err} !== '0) begin
            errors++; $display("FAIL reset_mid got=rdy%b valid%b addr%h done%b want=rdy1 others 0", req_ready, dbus_valid, dbus_addr, done); end
        @(posedge clk); #1;
        rst_n = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'h77;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || wb_we !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_abandon got=done%b we%b rdy%b want=0/0/1", done, wb_we, req_ready); end
        dbus_rvalid = 1'b0;
    endtask

    task automatic test_random();
        logic mr, mw, e_err, e_wbwe;
        logic [2:0] f3;
        logic [31:0] a, wd, rdat, e_addr, e_wd, e_wbd;
        logic [3:0] e_be;
        logic [4:0] r;
        int cls, rdy, rv, e_lat, e_vcnt;
        bit bus;
        for (int n = 0; n < 150; n++) begin
            cls  = int'($urandom_range(0, 9));
            mr   = (cls >= 2 && cls <= 5) || cls == 9;
            mw   = (cls >= 6);
            f3   = 3'($urandom);
            a    = $urandom; wd = $urandom; rdat = $urandom;
            r    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            rdy  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
            rv   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
            model(mr, mw, f3, a, wd, rdat, r, rdy, rv, bus, e_addr, e_be, e_wd, e_err, e_wbwe, e_wbd, e_lat, e_vcnt);
            do_txn(mr, mw, f3, a, wd, r, rdat, rdy, rv,
                   lat, vcnt, stab, o_addr, o_we, o_be, o_wd, o_err, o_wbwe, o_wbrd, o_wbd, pls);
            checks++; if (lat !== e_lat || vcnt !== e_vcnt || !pls || !stab) begin
                errors++; $display("FAIL rnd%0d_timing got=lat%0d valid%0d pulse%b stable%b want=lat%0d valid%0d 1 1", n, lat, vcnt, pls, stab, e_lat, e_vcnt); end
            checks++; if (o_err !== e_err || o_wbwe !== e_wbwe || o_wbrd !== r) begin
                errors++; $display("FAIL rnd%0d_status got=err%b we%b rd%0d want=err%b we%b rd%0d", n, o_err, o_wbwe, o_wbrd, e_err, e_wbwe, r); end
            if (bus) begin
                checks++; if ({o_addr, o_we, o_be, o_wd} !== {e_addr, mw, e_be, e_wd}) begin
                    errors++; $display("FAIL rnd%0d_bus got=%h/%b/%b/%h want=%h/%b/%b/%h", n, o_addr, o_we, o_be, o_wd, e_addr, mw, e_be, e_wd); end
            end
            if (!e_err && !(bus && mw)) begin
                checks++; if (o_wbd !== e_wbd) begin errors++; $display("FAIL rnd%0d_data got=%h want=%h", n, o_wbd, e_wbd); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        addr = '0; wdata = '0; rd = '0; dbus_ready = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_lw();
        test_lb_lbu();
        test_sh_wait();
        test_timeout();
        test_misaligned();
        test_rd0_and_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
